// File: rtl/sec_decoder_pkg.sv
// Shared types, defaults and Hamming position helpers for the SEC/SECDED location decoder.
package sec_decoder_pkg;

    localparam int DEF_DATA_BITS = 28;
    localparam int DEF_PAR_BITS  = 6;
    localparam int DEF_SECDED    = 1;
    localparam int DEF_LANES     = 1;

    typedef enum logic [1:0] {
        NO_ERR    = 2'd0,
        CORRECTED = 2'd1,
        PAR_ONLY  = 2'd2,
        UNCORR    = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYND   = 2'd1,
        SEARCH = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    // 1-based Hamming position carrying data bit j (j-th non-power-of-two position)
    function automatic int data_pos(input int j);
        int cnt;
        cnt = 0;
        for (int p = 1; p < 4096; p++) begin
            if (!is_pow2(p)) begin
                if (cnt == j) return p;
                cnt++;
            end
        end
        return 0;
    endfunction

endpackage

// File: rtl/sec_syndrome_gen.sv
// Combinational Hamming syndrome and overall parity of a latched codeword.
module sec_syndrome_gen #(
    parameter int N_POS    = 34,
    parameter int PAR_BITS = 6,
    parameter int CW_BITS  = 35
) (
    input  logic [CW_BITS-1:0]  cw,
    output logic [PAR_BITS-1:0] synd,
    output logic                par
);

    always_comb begin
        synd = '0;
        for (int i = 0; i < N_POS; i++) begin
            if (cw[i]) synd ^= PAR_BITS'(i + 1);
        end
        par = ^cw;
    end

endmodule

// File: rtl/sec_location_decoder_param.sv
// Clocked SEC/SECDED decoder: syndrome in one cycle, then a LANES-wide position search.
module sec_location_decoder_param
    import sec_decoder_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int PAR_BITS  = DEF_PAR_BITS,
    parameter int SECDED    = DEF_SECDED,
    parameter int LANES     = DEF_LANES,
    localparam int N_POS    = DATA_BITS + PAR_BITS,
    localparam int CW_BITS  = N_POS + SECDED,
    localparam int LOC_W    = PAR_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CW_BITS-1:0]   cw_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic [LOC_W-1:0]     err_loc,
    output logic [1:0]           status,
    output logic                 busy
);

    if (2**PAR_BITS < N_POS + 1) begin : g_bad_par
        $error("PAR_BITS too small for DATA_BITS");
    end
    if (LANES < 1 || LANES > N_POS) begin : g_bad_lanes
        $error("LANES out of range");
    end

    state_t                 state, state_nxt;
    logic [CW_BITS-1:0]     cw_r;
    logic [LOC_W-1:0]       s_r;
    logic [LOC_W:0]         pos_r;
    logic [LOC_W-1:0]       s_c;
    logic                   p_c;
    logic [LANES-1:0]       lane_hit;
    logic                   srch_hit;
    logic                   exhausted;
    logic [DATA_BITS-1:0]   data_c;
    logic                   res_load;
    status_t                status_nxt;
    logic [LOC_W-1:0]       loc_nxt;

    sec_syndrome_gen #(
        .N_POS    (N_POS),
        .PAR_BITS (PAR_BITS),
        .CW_BITS  (CW_BITS)
    ) u_synd (
        .cw   (cw_r),
        .synd (s_c),
        .par  (p_c)
    );

    // Lanes past N_POS are clipped so a syndrome beyond the word never matches
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [LOC_W+1:0] cand;
        assign cand        = {1'b0, pos_r} + (LOC_W+2)'(l);
        assign lane_hit[l] = (cand <= (LOC_W+2)'(N_POS)) && (cand == {2'b00, s_r});
    end

    assign srch_hit  = (state == SEARCH) && (|lane_hit);
    assign exhausted = ({1'b0, pos_r} + (LOC_W+2)'(LANES)) > (LOC_W+2)'(N_POS);

    for (genvar j = 0; j < DATA_BITS; j++) begin : g_data
        localparam int P = data_pos(j);
        assign data_c[j] = cw_r[P-1] ^ (srch_hit && (s_r == LOC_W'(P)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (in_valid) state_nxt = SYND;
            SYND: begin
                if (s_c == '0 || (SECDED != 0 && !p_c)) state_nxt = DONE;
                else                                   state_nxt = SEARCH;
            end
            SEARCH: if (srch_hit || exhausted) state_nxt = DONE;
            DONE:   if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state == IDLE);
        busy       = (state != IDLE);
        out_valid  = (state == DONE);
        res_load   = 1'b0;
        status_nxt = NO_ERR;
        loc_nxt    = '0;
        case (state)
            SYND: begin
                res_load = (s_c == '0) || (SECDED != 0 && !p_c);
                if (s_c == '0) status_nxt = (SECDED != 0 && p_c) ? PAR_ONLY : NO_ERR;
                else           status_nxt = UNCORR;
            end
            SEARCH: begin
                res_load = srch_hit || exhausted;
                if (srch_hit) begin
                    status_nxt = CORRECTED;
                    loc_nxt    = s_r;
                end else begin
                    status_nxt = UNCORR;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cw_r     <= '0;
            s_r      <= '0;
            pos_r    <= '0;
            data_out <= '0;
            err_loc  <= '0;
            status   <= NO_ERR;
        end else begin
            if (state == IDLE && in_valid) cw_r <= cw_in;
            if (state == SYND) begin
                s_r   <= s_c;
                pos_r <= (LOC_W+1)'(1);
            end else if (state == SEARCH && !srch_hit && !exhausted) begin
                pos_r <= pos_r + (LOC_W+1)'(LANES);
            end
            if (res_load) begin
                data_out <= data_c;
                err_loc  <= loc_nxt;
                status   <= status_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sec_location_decoder_param.sv
// Directed bench: default, LANES=4 and SECDED=0 builds driven one at a time.
module tb_sec_location_decoder_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic out_ready = 1'b0;
    always #5 clk = ~clk;

    logic        iv0 = 1'b0, ir0, ov0, bz0;
    logic [34:0] cw0 = '0;
    logic [27:0] d0;
    logic [5:0]  el0;
    logic [1:0]  st0;

    logic        iv1 = 1'b0, ir1, ov1, bz1;
    logic [34:0] cw1 = '0;
    logic [27:0] d1;
    logic [5:0]  el1;
    logic [1:0]  st1;

    logic        iv2 = 1'b0, ir2, ov2, bz2;
    logic [33:0] cw2 = '0;
    logic [27:0] d2;
    logic [5:0]  el2;
    logic [1:0]  st2;

    sec_location_decoder_param u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .cw_in(cw0),
        .out_valid(ov0), .out_ready(out_ready), .data_out(d0), .err_loc(el0),
        .status(st0), .busy(bz0));

    sec_location_decoder_param #(.LANES(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .cw_in(cw1),
        .out_valid(ov1), .out_ready(out_ready), .data_out(d1), .err_loc(el1),
        .status(st1), .busy(bz1));

    sec_location_decoder_param #(.SECDED(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .cw_in(cw2),
        .out_valid(ov2), .out_ready(out_ready), .data_out(d2), .err_loc(el2),
        .status(st2), .busy(bz2));

    int          sel = 0;
    int          total = 0;
    int          bad = 0;
    logic        ov, ir, bz;
    logic [27:0] dout;
    logic [5:0]  el;
    logic [1:0]  st;

    always_comb begin
        case (sel)
            1:       begin ov = ov1; ir = ir1; bz = bz1; dout = d1; el = el1; st = st1; end
            2:       begin ov = ov2; ir = ir2; bz = bz2; dout = d2; el = el2; st = st2; end
            default: begin ov = ov0; ir = ir0; bz = bz0; dout = d0; el = el0; st = st0; end
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference encoder: data into non-power-of-two positions, check bits zero the syndrome
    function automatic logic [34:0] enc(input logic [27:0] d);
        logic [34:0] c;
        logic [5:0]  s;
        int          j;
        c = '0;
        s = '0;
        j = 0;
        for (int p = 1; p <= 34; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[j];
                j++;
            end
        end
        for (int i = 0; i < 34; i++) if (c[i]) s ^= 6'(i + 1);
        for (int b = 0; b < 6; b++) c[(1 << b) - 1] = s[b];
        c[34] = ^c[33:0];
        return c;
    endfunction

    task automatic send(input logic [34:0] cw);
        @(negedge clk);
        case (sel)
            1:       begin cw1 = cw; iv1 = 1'b1; end
            2:       begin cw2 = cw[33:0]; iv2 = 1'b1; end
            default: begin cw0 = cw; iv0 = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!ov && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".ov_drop"}, ov, 1'b0);
        chk({tag, ".ir_back"}, ir, 1'b1);
    endtask

    task automatic run(input string tag, input logic [34:0] cw, input logic [1:0] e_st,
                       input logic [5:0] e_loc, input logic [27:0] e_d, input int e_lat);
        int n;
        send(cw);
        wait_out(n);
        chk({tag, ".lat"}, n, e_lat);
        chk({tag, ".st"}, st, e_st);
        chk({tag, ".loc"}, el, e_loc);
        chk({tag, ".data"}, dout, e_d);
        handoff(tag);
    endtask

    logic [34:0] cw_ff, cw_a5;
    int          n;

    initial begin
        cw_ff = enc(28'hFFFFFFF);
        cw_a5 = enc(28'hA5A5A5A);

        repeat (3) @(posedge clk);
        #1;
        chk("rst.ir", ir, 1'b1);
        chk("rst.ov", ov, 1'b0);
        chk("rst.busy", bz, 1'b0);
        chk("rst.data", dout, 28'h0);
        chk("rst.loc", el, 6'd0);
        chk("rst.st", st, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        sel = 0;
        run("clean_ff", cw_ff, 2'd0, 6'd0, 28'hFFFFFFF, 1);
        run("clean_zero", 35'h0, 2'd0, 6'd0, 28'h0, 1);
        run("pos21", cw_ff ^ (35'd1 << 20), 2'd1, 6'd21, 28'hFFFFFFF, 22);
        run("a5_pos3", cw_a5 ^ (35'd1 << 2), 2'd1, 6'd3, 28'hA5A5A5A, 4);
        run("dbl_4_11", cw_ff ^ (35'd1 << 3) ^ (35'd1 << 10), 2'd3, 6'd0, 28'hFFFFFBF, 1);
        run("par_only", cw_ff ^ (35'd1 << 34), 2'd2, 6'd0, 28'hFFFFFFF, 1);
        run("chk_pos2", cw_ff ^ (35'd1 << 1), 2'd1, 6'd2, 28'hFFFFFFF, 3);

        sel = 1;
        run("l4_pos34", cw_ff ^ (35'd1 << 33), 2'd1, 6'd34, 28'hFFFFFFF, 10);

        sel = 2;
        run("sec_s35", cw_ff ^ (35'd1 << 32) ^ (35'd1 << 1), 2'd3, 6'd0, 28'hBFFFFFF, 35);
        run("sec_pos21", cw_ff ^ (35'd1 << 20), 2'd1, 6'd21, 28'hFFFFFFF, 22);

        // Consumer stalls while a second word waits on in_valid
        sel = 0;
        send(cw_ff);
        wait_out(n);
        chk("hs.lat", n, 1);
        @(negedge clk);
        cw0 = cw_a5;
        iv0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("hs.ov_hold", ov, 1'b1);
            chk("hs.data_hold", dout, 28'hFFFFFFF);
            chk("hs.st_hold", st, 2'd0);
            chk("hs.ir_low", ir, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("hs.ov_drop", ov, 1'b0);
        chk("hs.ir_rise", ir, 1'b1);
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        chk("hs.accept2", ir, 1'b0);
        wait_out(n);
        chk("hs.lat2", n, 1);
        chk("hs.data2", dout, 28'hA5A5A5A);
        chk("hs.st2", st, 2'd0);
        handoff("hs2");

        // Reset in the middle of a search
        send(cw_ff ^ (35'd1 << 20));
        repeat (5) @(posedge clk);
        #1;
        chk("mid.busy_pre", bz, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid.ov", ov, 1'b0);
        chk("mid.ir", ir, 1'b1);
        chk("mid.busy", bz, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("mid.no_out", ov, 1'b0);
        run("post_rst", cw_a5, 2'd0, 6'd0, 28'hA5A5A5A, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
